oled_screen_fmt: RTL and testbench

//  Builds the 64-character (4 pages x 16 chars) screen image consumed by the OLED text driver.

---
 rtl/oled_screen_fmt_pkg.sv | 24 ++
 rtl/oled_screen_fmt_hex_ascii.sv | 18 +
 rtl/oled_screen_fmt.sv | 166 ++++++++++++++++
 tb/tb_oled_screen_fmt.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/oled_screen_fmt_pkg.sv
// Shared constants and state encoding for the OLED screen formatter.
package oled_screen_fmt_pkg;

    localparam int unsigned NUM_PAGES = 4;
    localparam int unsigned NUM_COLS  = 16;
    localparam int unsigned NUM_CHARS = NUM_PAGES * NUM_COLS;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned IMG_W     = NUM_CHARS * 8;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_COLON = 8'h3A;
    localparam logic [7:0] CHAR_0     = 8'h30;
    localparam logic [7:0] CHAR_A     = 8'h41;
    localparam logic [7:0] CHAR_a     = 8'h61;

    typedef enum logic [1:0] {
        FMT_IDLE   = 2'd0,
        FMT_CONV   = 2'd1,
        FMT_COMMIT = 2'd2
    } fmt_state_e;

endpackage

// File: rtl/oled_screen_fmt_hex_ascii.sv
// Combinational nibble to ASCII hex digit, case selectable.
module oled_screen_fmt_hex_ascii
    import oled_screen_fmt_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       upper_hex,
    output logic [7:0] ascii_c
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii_c = CHAR_0 + 8'(nibble);
        end else begin
            ascii_c = (upper_hex ? CHAR_A : CHAR_a) + 8'(4'(nibble - 4'd10));
        end
    end

endmodule

// File: rtl/oled_screen_fmt.sv
// Renders four snapshotted debug words as labelled hex lines and commits the
// finished 64-char image to char_data in one cycle.
module oled_screen_fmt
    import oled_screen_fmt_pkg::*;
#(
    parameter bit          UPPER_HEX = 1'b1,
    parameter logic [15:0] LABEL0    = 16'h5043,
    parameter logic [15:0] LABEL1    = 16'h4952,
    parameter logic [15:0] LABEL2    = 16'h5241,
    parameter logic [15:0] LABEL3    = 16'h5242
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WORD_W-1:0]  word0,
    input  logic [WORD_W-1:0]  word1,
    input  logic [WORD_W-1:0]  word2,
    input  logic [WORD_W-1:0]  word3,
    output logic               busy,
    output logic               done,
    output logic [IMG_W-1:0]   char_data
);

    fmt_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pending_q, pending_d;
    logic [WORD_W-1:0]  snap_q [NUM_PAGES];
    logic [WORD_W-1:0]  snap_d [NUM_PAGES];
    logic [7:0]         work_q [NUM_CHARS];
    logic [7:0]         work_d [NUM_CHARS];
    logic [IMG_W-1:0]   char_data_q, char_data_d;

    logic [WORD_W-1:0]  cur_word;
    logic [3:0]         cur_nibble;
    logic [7:0]         hex_char_c;
    logic [IDX_W-1:0]   wr_idx;
    logic               do_snap;

    function automatic logic [7:0] label_char(input logic [1:0] page, input logic hi);
        logic [15:0] lbl;
        case (page)
            2'd0:    lbl = LABEL0;
            2'd1:    lbl = LABEL1;
            2'd2:    lbl = LABEL2;
            default: lbl = LABEL3;
        endcase
        return hi ? lbl[15:8] : lbl[7:0];
    endfunction

    // cnt[4:3] selects the page, cnt[2:0] the digit, MSB nibble first
    assign cur_word   = snap_q[cnt_q[4:3]];
    assign cur_nibble = cur_word[5'd28 - {cnt_q[2:0], 2'b00} +: 4];
    assign wr_idx     = {cnt_q[4:3], 4'(4'd4 + 4'(cnt_q[2:0]))};

    oled_screen_fmt_hex_ascii u_hex_ascii (
        .nibble    (cur_nibble),
        .upper_hex (UPPER_HEX),
        .ascii_c   (hex_char_c)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pending_d   = pending_q;
        snap_d      = snap_q;
        work_d      = work_q;
        char_data_d = char_data_q;
        do_snap     = 1'b0;

        unique case (state_q)
            FMT_IDLE: begin
                if (start) begin
                    do_snap = 1'b1;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = FMT_CONV;
                end
            end
            FMT_CONV: begin
                work_d[wr_idx] = hex_char_c;
                cnt_d          = CNT_W'(cnt_q + 5'd1);
                if (start) begin
                    pending_d = 1'b1;
                end
                if (cnt_q == 5'd31) begin
                    state_d = FMT_COMMIT;
                end
            end
            FMT_COMMIT: begin
                for (int k = 0; k < 64; k++) begin
                    char_data_d[8*(63-k) +: 8] = work_q[k];
                end
                done_d = 1'b1;
                // a start landing on the commit edge counts as pending
                if (pending_q || start) begin
                    pending_d = 1'b0;
                    do_snap   = 1'b1;
                    cnt_d     = '0;
                    state_d   = FMT_CONV;
                end else begin
                    busy_d  = 1'b0;
                    state_d = FMT_IDLE;
                end
            end
            default: begin
                state_d = FMT_IDLE;
            end
        endcase

        // snapshot and static label/separator chars on every CONV entry
        if (do_snap) begin
            snap_d[0] = word0;
            snap_d[1] = word1;
            snap_d[2] = word2;
            snap_d[3] = word3;
            for (int p = 0; p < 4; p++) begin
                for (int c = 0; c < 16; c++) begin
                    if (c == 0) begin
                        work_d[IDX_W'(p*16 + c)] = label_char(2'(p), 1'b1);
                    end else if (c == 1) begin
                        work_d[IDX_W'(p*16 + c)] = label_char(2'(p), 1'b0);
                    end else if (c == 2) begin
                        work_d[IDX_W'(p*16 + c)] = CHAR_COLON;
                    end else if (c == 3 || c >= 12) begin
                        work_d[IDX_W'(p*16 + c)] = CHAR_SPACE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FMT_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pending_q   <= 1'b0;
            char_data_q <= {NUM_CHARS{CHAR_SPACE}};
            for (int i = 0; i < 4; i++) begin
                snap_q[i] <= '0;
            end
            for (int i = 0; i < 64; i++) begin
                work_q[i] <= CHAR_SPACE;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pending_q   <= pending_d;
            char_data_q <= char_data_d;
            snap_q      <= snap_d;
            work_q      <= work_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign char_data = char_data_q;

endmodule

// File: tb/tb_oled_screen_fmt.sv
// Directed bench for oled_screen_fmt: uppercase and lowercase instances share stimulus.
module tb_oled_screen_fmt;

    logic         clk;
    logic         rst;
    logic         start;
    logic [31:0]  word0, word1, word2, word3;
    logic         busy, done;
    logic [511:0] char_data;
    logic         busy_lc, done_lc;
    logic [511:0] char_data_lc;

    int checks;
    int errors;

    localparam logic [511:0] SPACES = {64{8'h20}};

    oled_screen_fmt #(.UPPER_HEX(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start),
        .word0(word0), .word1(word1), .word2(word2), .word3(word3),
        .busy(busy), .done(done), .char_data(char_data)
    );

    oled_screen_fmt #(.UPPER_HEX(1'b0)) dut_lc (
        .clk(clk), .rst(rst), .start(start),
        .word0(word0), .word1(word1), .word2(word2), .word3(word3),
        .busy(busy_lc), .done(done_lc), .char_data(char_data_lc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] page_of(input logic [511:0] cd, input int p);
        return cd[511-128*p -: 128];
    endfunction

    function automatic logic [7:0] char_of(input logic [511:0] cd, input int k);
        return cd[8*(63-k) +: 8];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit found, output int n);
        found = 1'b0;
        n = 0;
        while (!found && n < max) begin
            tick();
            n++;
            if (done) found = 1'b1;
        end
    endtask

    task automatic set_words(input logic [31:0] a, b, c, d);
        word0 = a; word1 = b; word2 = c; word3 = d;
    endtask

    initial begin
        bit found;
        int n;
        int d1, d2, ndone;
        bit saw_done;
        logic [511:0] img1, img2;

        checks = 0;
        errors = 0;
        start  = 1'b0;
        set_words(32'h0, 32'h0, 32'h0, 32'h0);

        // reset asserted before any clock edge
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_chars", char_data, SPACES);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        #1 rst = 1'b0;
        tick();
        tick();

        // basic conversion with exact latency
        set_words(32'h0123ABCD, 32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF);
        pulse_start();
        check("basic_busy_up", busy, 1'b1);
        repeat (32) tick();
        check("basic_no_early_done", done, 1'b0);
        check("basic_hold_before_commit", char_data, SPACES);
        tick();
        check("basic_done_at_33", done, 1'b1);
        check("basic_busy_falls", busy, 1'b0);
        check("basic_page0", page_of(char_data, 0), "PC: 0123ABCD    ");
        check("basic_page1", page_of(char_data, 1), "IR: DEADBEEF    ");
        check("basic_page2", page_of(char_data, 2), "RA: 00000000    ");
        check("basic_page3", page_of(char_data, 3), "RB: FFFFFFFF    ");
        check("basic_lc_page0", page_of(char_data_lc, 0), "PC: 0123abcd    ");
        tick();
        check("basic_done_one_cycle", done, 1'b0);
        check("basic_hold_after", page_of(char_data, 3), "RB: FFFFFFFF    ");

        // word change during CONV must not leak into the image
        set_words(32'h89ABCDEF, 32'h0, 32'h0, 32'h0);
        pulse_start();
        repeat (4) tick();
        word0 = 32'h55555555;
        wait_done(60, found, n);
        check("snap_done_seen", found, 1'b1);
        check("snap_latency", 32'(n), 32'd29);
        check("snap_page0", page_of(char_data, 0), "PC: 89ABCDEF    ");
        check("snap_lc_page0", page_of(char_data_lc, 0), "PC: 89abcdef    ");
        tick();
        tick();

        // three starts during CONV collapse into one pending rerun
        set_words(32'h13579BDF, 32'h2468ACE0, 32'h0F1E2D3C, 32'h00000000);
        pulse_start();
        d1 = 0; d2 = 0; ndone = 0;
        img1 = '0; img2 = '0;
        for (int c = 1; c <= 75; c++) begin
            start = (c == 3 || c == 10 || c == 20);
            if (c == 25) set_words(32'hCAFEF00D, 32'h0BADC0DE, 32'h12345678, 32'h9ABCDEF0);
            if (c == 34) set_words(32'h77777777, 32'h77777777, 32'h77777777, 32'h77777777);
            tick();
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    d1 = c; img1 = char_data;
                    check("pend_busy_held", busy, 1'b1);
                end else if (ndone == 2) begin
                    d2 = c; img2 = char_data;
                end
            end
        end
        start = 1'b0;
        check("pend_done_count", 32'(ndone), 32'd2);
        check("pend_first_at", 32'(d1), 32'd33);
        check("pend_spacing", 32'(d2 - d1), 32'd33);
        check("pend_img1_p0", page_of(img1, 0), "PC: 13579BDF    ");
        check("pend_img1_p1", page_of(img1, 1), "IR: 2468ACE0    ");
        check("pend_img1_p2", page_of(img1, 2), "RA: 0F1E2D3C    ");
        check("pend_img2_p0", page_of(img2, 0), "PC: CAFEF00D    ");
        check("pend_img2_p3", page_of(img2, 3), "RB: 9ABCDEF0    ");
        check("pend_idle_after", busy, 1'b0);

        // lowercase vs uppercase of the last digit
        set_words(32'h0000000F, 32'h0, 32'h0, 32'h0);
        pulse_start();
        wait_done(60, found, n);
        check("lc_done_seen", found, 1'b1);
        check("lc_char11", char_of(char_data_lc, 11), 8'h66);
        check("uc_char11", char_of(char_data, 11), 8'h46);
        check("lc_char4", char_of(char_data_lc, 4), 8'h30);
        tick();

        // async reset mid-CONV aborts and clears the image
        set_words(32'hA5A5A5A5, 32'h1, 32'h2, 32'h3);
        pulse_start();
        repeat (9) tick();
        #3 rst = 1'b1;
        #1;
        check("midrst_chars", char_data, SPACES);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        #2 rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        check("midrst_no_done", saw_done, 1'b0);
        check("midrst_still_spaces", char_data, SPACES);

        set_words(32'h0, 32'h0, 32'h0, 32'h600DF00D);
        pulse_start();
        wait_done(60, found, n);
        check("after_rst_done_seen", found, 1'b1);
        check("after_rst_latency", 32'(n), 32'd33);
        check("after_rst_page3", page_of(char_data, 3), "RB: 600DF00D    ");
        check("after_rst_page0", page_of(char_data, 0), "PC: 00000000    ");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
